pc_fetch_unit: RTL and testbench

//  Program-counter and instruction-fetch stage of the MIPS core. Holds the PC and

---
 rtl/pc_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// PC / instruction-fetch stage: req/ack fetch from imem, one word handed to decode at a time.
// Optional build macro DELAY_SLOT_EN: deliver the in-flight/held word on redirect instead of squashing it.
module pc_fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic [ADDR_W-1:0] branch_base,
    input  logic [15:0]       branch_imm,
    input  logic [25:0]       jump_index,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4
);

`ifdef DELAY_SLOT_EN
    localparam bit SQUASH_EN = 1'b0;
`else
    localparam bit SQUASH_EN = 1'b1;
`endif

    typedef enum logic [1:0] {ST_START, ST_FETCH, ST_VALID} state_t;

    state_t            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_pend_target, w_pend_target_next;
    logic              r_pending, w_pending_next;
    logic              r_squash, w_squash_next;
    logic [31:0]       r_instr, w_instr_next;
    logic [ADDR_W-1:0] r_pc_out, w_pc_out_next;
    logic [ADDR_W-1:0] r_pc_plus4, w_pc_plus4_next;

    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_branch_target;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next_target;
    logic [ADDR_W-1:0] w_seq_pc;
    logic              w_redirect;
    logic              w_take_target;

    generate
        if (ADDR_W > 28) begin : g_jt_wide
            assign w_jump_target = {branch_base[ADDR_W-1:28], jump_index, 2'b00};
        end else begin : g_jt_narrow
            assign w_jump_target = {jump_index, 2'b00};
        end
    endgenerate

    assign w_branch_target = branch_base + {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};
    assign w_target        = jump ? w_jump_target : w_branch_target;
    assign w_redirect      = (jump | branch_taken) &
                             ((r_state == ST_FETCH) | (r_state == ST_VALID));
    // A redirect arriving this cycle supersedes any older pending target.
    assign w_next_target   = w_redirect ? w_target : r_pend_target;
    assign w_take_target   = w_redirect | r_pending;
    assign w_seq_pc        = r_pc + ADDR_W'(4);

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_pend_target_next = r_pend_target;
        w_pending_next     = r_pending;
        w_squash_next      = r_squash;
        w_instr_next       = r_instr;
        w_pc_out_next      = r_pc_out;
        w_pc_plus4_next    = r_pc_plus4;

        if (w_redirect) begin
            w_pend_target_next = w_target;
            w_pending_next     = 1'b1;
        end

        case (r_state)
            ST_START: w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (imem_ack) begin
                    if (r_squash || (SQUASH_EN && w_redirect)) begin
                        w_pc_next      = w_next_target;
                        w_pending_next = 1'b0;
                        w_squash_next  = 1'b0;
                    end else begin
                        w_instr_next    = imem_data;
                        w_pc_out_next   = r_pc;
                        w_pc_plus4_next = w_seq_pc;
                        w_state_next    = ST_VALID;
                    end
                end else if (SQUASH_EN && w_redirect) begin
                    w_squash_next = 1'b1;
                end
            end
            ST_VALID: begin
                // In squash mode a redirect drops the held word even under stall.
                if ((SQUASH_EN && w_redirect) || !stall) begin
                    w_state_next   = ST_FETCH;
                    w_pc_next      = w_take_target ? w_next_target : w_seq_pc;
                    w_pending_next = 1'b0;
                end
            end
            default: w_state_next = ST_START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_START;
            r_pc          <= RESET_VECTOR;
            r_pend_target <= '0;
            r_pending     <= 1'b0;
            r_squash      <= 1'b0;
            r_instr       <= '0;
            r_pc_out      <= '0;
            r_pc_plus4    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_pend_target <= w_pend_target_next;
            r_pending     <= w_pending_next;
            r_squash      <= w_squash_next;
            r_instr       <= w_instr_next;
            r_pc_out      <= w_pc_out_next;
            r_pc_plus4    <= w_pc_plus4_next;
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == ST_VALID);
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign pc_plus4    = r_pc_plus4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, stall, branch/jump redirect, reset abort.
// Built with DELAY_SLOT_EN it also checks delay-slot delivery.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic [31:0] branch_base;
    logic [15:0] branch_imm;
    logic [25:0] jump_index;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;

    int tests = 0;
    int fails = 0;

    pc_fetch_unit #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .branch_base  (branch_base),
        .branch_imm   (branch_imm),
        .jump_index   (jump_index),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic expect_fetch(input string tag, input logic [31:0] addr);
        check({tag, "_req"},   32'(imem_req),    32'd1);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_addr"},  imem_addr,        addr);
        $display("[TB] %s fetch addr=%h", tag, imem_addr);
    endtask

    task automatic expect_valid(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check({tag, "_req"},   32'(imem_req),    32'd0);
        check({tag, "_pc"},    pc_out,           pc);
        check({tag, "_pc4"},   pc_plus4,         pc + 32'd4);
        check({tag, "_instr"}, instr_out,        word(pc));
        $display("[TB] %s valid pc=%h instr=%h", tag, pc_out, instr_out);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, "_req"},   32'(imem_req),    32'd0);
        check({tag, "_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr_out,        32'd0);
        check({tag, "_pc"},    pc_out,           32'd0);
        check({tag, "_pc4"},   pc_plus4,         32'd0);
        check({tag, "_addr"},  imem_addr,        32'd0);
        $display("[TB] %s reset state", tag);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_base = '0; branch_imm = '0; jump_index = '0;
        imem_ack = 1'b0; imem_data = '0;

        tick;
        expect_reset("rst");
        rst_n = 1'b1;

        // Sequential fetch with single-cycle ack
        tick; expect_fetch("seq0", 32'h0);
        imem_ack = 1'b1; imem_data = word(32'h0);
        tick; imem_ack = 1'b0; expect_valid("seq0", 32'h0);
        tick; expect_fetch("seq4", 32'h4);
        imem_ack = 1'b1; imem_data = word(32'h4);
        tick; imem_ack = 1'b0; expect_valid("seq4", 32'h4);
        tick; expect_fetch("seq8", 32'h8);
        imem_ack = 1'b1; imem_data = word(32'h8);
        tick; imem_ack = 1'b0; expect_valid("seq8", 32'h8);

        // Stall holds the word for three cycles
        stall = 1'b1;
        tick; expect_valid("stall1", 32'h8);
        tick; expect_valid("stall2", 32'h8);
        tick; expect_valid("stall3", 32'h8);
        stall = 1'b0;
        tick; expect_fetch("after_stall", 32'hC);

`ifndef DELAY_SLOT_EN
        // Branch during fetch: address stays put, returning word squashed
        branch_taken = 1'b1; branch_base = 32'h10; branch_imm = 16'hFFFC;
        tick; branch_taken = 1'b0;
        expect_fetch("br_hold", 32'hC);
        imem_ack = 1'b1; imem_data = word(32'hC);
        tick; imem_data = word(32'h0);
        expect_fetch("br_target", 32'h0);
        tick; imem_ack = 1'b0; expect_valid("br_deliver", 32'h0);

        // Redirect beats stall in VALID
        stall = 1'b1; branch_taken = 1'b1; branch_base = 32'h100; branch_imm = 16'h0004;
        tick; stall = 1'b0; branch_taken = 1'b0;
        expect_fetch("br_valid_stall", 32'h110);

        // Jump + branch with ack in the same cycle: jump wins, word squashed
        jump = 1'b1; branch_taken = 1'b1; branch_base = 32'h8000_0004;
        jump_index = 26'h0000040; branch_imm = 16'h0001;
        imem_ack = 1'b1; imem_data = word(32'h110);
        tick; jump = 1'b0; branch_taken = 1'b0;
        imem_data = word(32'h8000_0100);
        expect_fetch("jmp_target", 32'h8000_0100);
        tick; imem_ack = 1'b0; expect_valid("jmp_deliver", 32'h8000_0100);
        tick; expect_fetch("jmp_next", 32'h8000_0104);
`else
        // Delay slot: word in flight at redirect time is still delivered
        branch_taken = 1'b1; branch_base = 32'h10; branch_imm = 16'h0004;
        tick; branch_taken = 1'b0;
        expect_fetch("ds_hold", 32'hC);
        imem_ack = 1'b1; imem_data = word(32'hC);
        tick; imem_ack = 1'b0; expect_valid("ds_slot", 32'hC);
        tick; expect_fetch("ds_target", 32'h20);

        // Redirect coinciding with ack: word also delivered
        jump = 1'b1; branch_base = 32'h4; jump_index = 26'h0000010;
        imem_ack = 1'b1; imem_data = word(32'h20);
        tick; jump = 1'b0; imem_ack = 1'b0;
        expect_valid("ds_ack_slot", 32'h20);
        tick; expect_fetch("ds_jmp_target", 32'h40);
`endif

        // Asynchronous reset mid-fetch; acks during reset ignored
        #2; rst_n = 1'b0;
        #1; expect_reset("rst_async");
        imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
        tick; tick;
        expect_reset("rst_hold");
        rst_n = 1'b1; imem_ack = 1'b0;
        tick; expect_fetch("rst_refetch", 32'h0);
        imem_ack = 1'b1; imem_data = word(32'h0);
        tick; imem_ack = 1'b0; expect_valid("rst_deliver", 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
